// File: rtl/rggen_bus_splitter_pkg.sv
// rggen_bus_splitter_pkg: response status codes and access-type bit positions shared by the bus blocks.
package rggen_bus_splitter_pkg;
    typedef enum logic [1:0] {
        STATUS_OKAY         = 2'b00,
        STATUS_EXOKAY       = 2'b01,
        STATUS_SLAVE_ERROR  = 2'b10,
        STATUS_DECODE_ERROR = 2'b11
    } status_e;
    localparam int ACCESS_WRITE_BIT = 0;
endpackage

// File: rtl/rggen_mux.sv
// rggen_mux: one-hot selection of one WIDTH-bit word out of ENTRIES.
module rggen_mux #(
    parameter int WIDTH   = 1,
    parameter int ENTRIES = 2
) (
    input  logic [ENTRIES-1:0]       i_select,
    input  logic [WIDTH*ENTRIES-1:0] i_data,
    output logic [WIDTH-1:0]         o_data
);
    always_comb begin
        o_data = '0;
        for (int i = 0; i < ENTRIES; i++) o_data = o_data | ({WIDTH{i_select[i]}} & i_data[WIDTH*i+:WIDTH]);
    end
endmodule

// File: rtl/rggen_bus_splitter.sv
// rggen_bus_splitter: decodes one host access onto one of TARGETS register blocks and returns its response.
module rggen_bus_splitter
    import rggen_bus_splitter_pkg::*;
#(
    parameter int                                ADDRESS_WIDTH       = 16,
    parameter int                                LOCAL_ADDRESS_WIDTH = 8,
    parameter int                                BUS_WIDTH           = 32,
    parameter int                                TARGETS             = 2,
    parameter logic [TARGETS*ADDRESS_WIDTH-1:0] BASE_ADDRESSES      = '0,
    parameter int                                TIMEOUT_CYCLES      = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_host_valid,
    input  logic [1:0]                     i_host_access,
    input  logic [ADDRESS_WIDTH-1:0]       i_host_address,
    input  logic [BUS_WIDTH-1:0]           i_host_write_data,
    input  logic [BUS_WIDTH-1:0]           i_host_strobe,
    output logic                           o_host_ready,
    output logic [1:0]                     o_host_status,
    output logic [BUS_WIDTH-1:0]           o_host_read_data,
    output logic [TARGETS-1:0]             o_target_valid,
    output logic [1:0]                     o_target_access,
    output logic [LOCAL_ADDRESS_WIDTH-1:0] o_target_address,
    output logic [BUS_WIDTH-1:0]           o_target_write_data,
    output logic [BUS_WIDTH-1:0]           o_target_strobe,
    input  logic [TARGETS-1:0]             i_target_ready,
    input  logic [2*TARGETS-1:0]           i_target_status,
    input  logic [BUS_WIDTH*TARGETS-1:0]   i_target_read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;
    localparam int UW = ADDRESS_WIDTH - LOCAL_ADDRESS_WIDTH;
    localparam int MW = 2 + BUS_WIDTH;
    state_e                         state_q;
    logic [TARGETS-1:0]             valid_q;
    logic [TARGETS-1:0]             hit;
    logic [1:0]                     access_q;
    logic [LOCAL_ADDRESS_WIDTH-1:0] address_q;
    logic [BUS_WIDTH-1:0]           write_data_q;
    logic [BUS_WIDTH-1:0]           strobe_q;
    logic                           host_ready_q;
    logic [1:0]                     status_q;
    logic [BUS_WIDTH-1:0]           read_data_q;
    logic [31:0]                    count_q;
    logic [MW*TARGETS-1:0]          mux_in;
    logic [MW-1:0]                  mux_out;
    logic                           ready;
    logic                           timeout;
    // Scan downward so the lowest matching window ends up as the select.
    always_comb begin
        hit = '0;
        for (int k = TARGETS - 1; k >= 0; k--) begin
            if (i_host_address[ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH] == BASE_ADDRESSES[ADDRESS_WIDTH*k+LOCAL_ADDRESS_WIDTH+:UW]) begin
                hit = '0;
                hit[k] = 1'b1;
            end
        end
    end
    for (genvar k = 0; k < TARGETS; k++) begin : g_in
        assign mux_in[MW*k+:MW] = {i_target_status[2*k+:2], i_target_read_data[BUS_WIDTH*k+:BUS_WIDTH]};
    end
    rggen_mux #(.WIDTH(MW), .ENTRIES(TARGETS)) u_mux (
        .i_select (valid_q),
        .i_data   (mux_in),
        .o_data   (mux_out)
    );
    assign ready   = |(i_target_ready & valid_q);
    assign timeout = (TIMEOUT_CYCLES > 0) && (count_q + 32'd1 == 32'(TIMEOUT_CYCLES));
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            access_q     <= '0;
            address_q    <= '0;
            write_data_q <= '0;
            strobe_q     <= '0;
            host_ready_q <= 1'b0;
            status_q     <= '0;
            read_data_q  <= '0;
            count_q      <= '0;
        end else begin
            host_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_host_valid && |hit) begin
                        valid_q      <= hit;
                        access_q     <= i_host_access;
                        address_q    <= i_host_address[LOCAL_ADDRESS_WIDTH-1:0];
                        write_data_q <= i_host_write_data;
                        strobe_q     <= i_host_strobe;
                        count_q      <= '0;
                        state_q      <= ACCESS;
                    end else if (i_host_valid) begin
                        status_q     <= STATUS_DECODE_ERROR;
                        read_data_q  <= '0;
                        host_ready_q <= 1'b1;
                        state_q      <= RESPOND;
                    end
                end
                ACCESS: begin
                    if (ready || timeout) begin
                        valid_q      <= '0;
                        host_ready_q <= 1'b1;
                        status_q     <= ready ? mux_out[BUS_WIDTH+:2] : STATUS_SLAVE_ERROR;
                        read_data_q  <= (!ready || access_q[ACCESS_WRITE_BIT] || mux_out[BUS_WIDTH+1]) ? '0 : mux_out[BUS_WIDTH-1:0];
                        state_q      <= RESPOND;
                    end else begin
                        count_q <= count_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign o_host_ready        = host_ready_q;
    assign o_host_status       = status_q;
    assign o_host_read_data    = read_data_q;
    assign o_target_valid      = valid_q;
    assign o_target_access     = access_q;
    assign o_target_address    = address_q;
    assign o_target_write_data = write_data_q;
    assign o_target_strobe     = strobe_q;
endmodule

// File: tb/tb_rggen_bus_splitter.sv
// tb_rggen_bus_splitter: vector table plus randomized accesses against a window-decode reference model.
module tb_rggen_bus_splitter;
    localparam int T  = 2;
    localparam int TO = 4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hv = 1'b0;
    logic [1:0]  hacc = '0;
    logic [15:0] haddr = '0;
    logic [31:0] hwd = '0;
    logic [31:0] hsb = '0;
    logic        o_hr;
    logic [1:0]  o_hs;
    logic [31:0] o_hrd;
    logic [1:0]  o_tv;
    logic [1:0]  o_tacc;
    logic [7:0]  o_ta;
    logic [31:0] o_twd;
    logic [31:0] o_tsb;
    logic [1:0]  tready = '0;
    logic [3:0]  tstat = '0;
    logic [63:0] trd = '0;
    int checks = 0;
    int fails = 0;
    logic [15:0] base_tab [T] = '{16'h0000, 16'h0100};

    always #5 clk = ~clk;

    rggen_bus_splitter #(
        .ADDRESS_WIDTH(16), .LOCAL_ADDRESS_WIDTH(8), .BUS_WIDTH(32), .TARGETS(T),
        .BASE_ADDRESSES({16'h0100, 16'h0000}), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_host_valid(hv), .i_host_access(hacc), .i_host_address(haddr),
        .i_host_write_data(hwd), .i_host_strobe(hsb),
        .o_host_ready(o_hr), .o_host_status(o_hs), .o_host_read_data(o_hrd),
        .o_target_valid(o_tv), .o_target_access(o_tacc), .o_target_address(o_ta),
        .o_target_write_data(o_twd), .o_target_strobe(o_tsb),
        .i_target_ready(tready), .i_target_status(tstat), .i_target_read_data(trd)
    );

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  acc;
        logic [31:0] wd;
        logic [31:0] sb;
        int          dly;
        logic [1:0]  ts0;
        logic [1:0]  ts1;
        logic [31:0] td0;
        logic [31:0] td1;
        bit          rogue;
        bit          drop;
    } vec_t;
    typedef struct {
        logic [1:0]  st;
        logic [31:0] rd;
        int          lat;
        int          vc;
        logic [1:0]  tv;
    } exp_t;
    typedef struct {
        vec_t v;
        exp_t e;
    } rec_t;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Reference: window = address / window size; lowest matching target wins; a target slower than TO cycles times out.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        int k = -1;
        logic [1:0] st;
        for (int i = T - 1; i >= 0; i--) if (int'(v.addr) / 256 == int'(base_tab[i]) / 256) k = i;
        e.tv = '0;
        if (k < 0) begin
            e.st = 2'b11; e.rd = '0; e.lat = 1; e.vc = 0;
        end else if (v.dly >= TO) begin
            e.st = 2'b10; e.rd = '0; e.lat = TO + 1; e.vc = TO; e.tv[k] = 1'b1;
        end else begin
            st = (k == 1) ? v.ts1 : v.ts0;
            e.st = st;
            e.rd = (v.acc[0] || st[1]) ? 32'h0 : ((k == 1) ? v.td1 : v.td0);
            e.lat = v.dly + 2;
            e.vc = v.dly + 1;
            e.tv[k] = 1'b1;
        end
        return e;
    endfunction

    task automatic run(input string n, input vec_t v, input exp_t e);
        int vcnt = 0;
        int lat = 0;
        logic [1:0] seen = '0;
        logic [1:0] st = '0;
        logic [31:0] rd = '0;
        bit cmd_ok = 1'b1;
        bit got = 1'b0;
        @(negedge clk);
        hv = 1'b1; hacc = v.acc; haddr = v.addr; hwd = v.wd; hsb = v.sb;
        tstat = {v.ts1, v.ts0}; trd = {v.td1, v.td0}; tready = '0;
        for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
            @(negedge clk);
            if (o_hr) begin
                got = 1'b1; lat = cyc; st = o_hs; rd = o_hrd; hv = 1'b0; tready = '0;
            end else begin
                seen |= o_tv;
                if (o_tv != 0) begin
                    vcnt++;
                    if (o_ta !== v.addr[7:0] || o_tacc !== v.acc || o_twd !== v.wd || o_tsb !== v.sb) cmd_ok = 1'b0;
                    if (v.drop) begin hv = 1'b0; haddr = ~v.addr; hwd = ~v.wd; hsb = ~v.sb; end
                end
                tready = v.rogue ? ~o_tv : 2'b00;
                if (o_tv != 0 && vcnt == v.dly + 1) tready |= o_tv;
            end
        end
        chk({n, "_ready_seen"}, 32'(got), 32'd1);
        chk({n, "_latency"}, lat, e.lat);
        chk({n, "_status"}, 32'(st), 32'(e.st));
        chk({n, "_read_data"}, rd, e.rd);
        chk({n, "_valid_cycles"}, vcnt, e.vc);
        chk({n, "_target_valid"}, 32'(seen), 32'(e.tv));
        chk({n, "_cmd_stable"}, 32'(cmd_ok), 32'd1);
        @(negedge clk);
        chk({n, "_ready_pulse"}, 32'(o_hr), 32'd0);
    endtask

    rec_t tab [9];
    vec_t rv;

    initial begin
        tab[0] = '{'{16'h0104, 2'b00, 32'h0, 32'h0, 0, 2'b00, 2'b00, 32'h11111111, 32'hCAFEF00D, 1'b0, 1'b0},
                   '{2'b00, 32'hCAFEF00D, 2, 1, 2'b10}};
        tab[1] = '{'{16'h0010, 2'b01, 32'h12345678, 32'hFFFFFFFF, 3, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0},
                   '{2'b00, 32'h0, 5, 4, 2'b01}};
        tab[2] = '{'{16'h0300, 2'b00, 32'h0, 32'h0, 0, 2'b00, 2'b00, 32'h1, 32'h2, 1'b0, 1'b0},
                   '{2'b11, 32'h0, 1, 0, 2'b00}};
        tab[3] = '{'{16'h0020, 2'b00, 32'h0, 32'h0, 9, 2'b01, 2'b00, 32'h55555555, 32'h0, 1'b0, 1'b0},
                   '{2'b10, 32'h0, 5, 4, 2'b01}};
        tab[4] = '{'{16'h01FC, 2'b00, 32'h0, 32'h0, 1, 2'b10, 2'b01, 32'hBAD0BAD0, 32'hA5A5A5A5, 1'b1, 1'b0},
                   '{2'b01, 32'hA5A5A5A5, 3, 2, 2'b10}};
        tab[5] = '{'{16'h0180, 2'b00, 32'h0, 32'h0, 2, 2'b00, 2'b10, 32'h0, 32'h00000077, 1'b0, 1'b0},
                   '{2'b10, 32'h0, 4, 3, 2'b10}};
        tab[6] = '{'{16'h0044, 2'b00, 32'h0, 32'h0, 2, 2'b01, 2'b00, 32'h0BADF00D, 32'h0, 1'b0, 1'b1},
                   '{2'b01, 32'h0BADF00D, 4, 3, 2'b01}};
        tab[7] = '{'{16'h00FF, 2'b00, 32'h0, 32'h0, 0, 2'b00, 2'b00, 32'h13579BDF, 32'h0, 1'b0, 1'b0},
                   '{2'b00, 32'h13579BDF, 2, 1, 2'b01}};
        tab[8] = '{'{16'h0100, 2'b01, 32'hA0A0A0A0, 32'h0000FFFF, 0, 2'b00, 2'b01, 32'h0, 32'h0000FFFF, 1'b0, 1'b0},
                   '{2'b01, 32'h0, 2, 1, 2'b10}};
        repeat (3) @(negedge clk);
        chk("rst_host_ready", 32'(o_hr), 32'd0);
        chk("rst_host_status", 32'(o_hs), 32'd0);
        chk("rst_host_read_data", o_hrd, 32'd0);
        chk("rst_target_valid", 32'(o_tv), 32'd0);
        chk("rst_target_access", 32'(o_tacc), 32'd0);
        chk("rst_target_address", 32'(o_ta), 32'd0);
        chk("rst_target_write_data", o_twd, 32'd0);
        chk("rst_target_strobe", o_tsb, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) run($sformatf("vec%0d", i), tab[i].v, tab[i].e);
        // Reset in the middle of an access: no response, everything back to zero.
        @(negedge clk);
        hv = 1'b1; hacc = 2'b01; haddr = 16'h0104; hwd = 32'h89ABCDEF; hsb = 32'hFFFFFFFF; tready = '0;
        @(negedge clk);
        chk("midrst_valid_before", 32'(o_tv), 32'h2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_target_valid", 32'(o_tv), 32'd0);
        chk("midrst_host_ready", 32'(o_hr), 32'd0);
        chk("midrst_target_address", 32'(o_ta), 32'd0);
        chk("midrst_target_write_data", o_twd, 32'd0);
        chk("midrst_target_access", 32'(o_tacc), 32'd0);
        rst_n = 1'b1; hv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_quiet%0d", i), 32'({o_hr, o_tv}), 32'd0);
        end
        run("after_rst", tab[0].v, tab[0].e);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       rv.addr = {8'h00, 8'($urandom)};
                1:       rv.addr = {8'h01, 8'($urandom)};
                default: rv.addr = 16'($urandom);
            endcase
            rv.acc = 2'($urandom); rv.wd = $urandom; rv.sb = $urandom;
            rv.dly = int'($urandom_range(0, 5));
            rv.ts0 = 2'($urandom); rv.ts1 = 2'($urandom);
            rv.td0 = $urandom; rv.td1 = $urandom;
            rv.rogue = 1'($urandom); rv.drop = 1'($urandom);
            run($sformatf("rand%0d", i), rv, model(rv));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end
endmodule
